// File: rtl/ext_pipe.sv
// ext_pipe: two-stage valid/ready immediate extender; 6 extension modes, eop 110/111 flag err. Optional cnt port under EXT_PIPE_CNT_EN.
// Latency: a word accepted at edge N is presented on ext/err after edge N+1; sustains one word per cycle.
// Backpressure: S2 holds under out_ready=0, S1 fills behind it, then in_ready drops; release moves both with no bubble.
module ext_pipe #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int SHAMT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] imm,
    input  logic [2:0]       eop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ext,
`ifdef EXT_PIPE_CNT_EN
    output logic [15:0]      cnt,
`endif
    output logic             err
);

    localparam int HI_W = OUT_W - IMM_W;

    typedef struct packed {
        logic [OUT_W-1:0] ext;
        logic             err;
    } res_t;

    logic [OUT_W-1:0] sx;
    logic [OUT_W-1:0] zx;
    res_t             res;

    logic             s1_vld;
    res_t             s1_dat;
    logic             s2_vld;
    res_t             s2_dat;

    logic             s1_adv;
    logic             accept;

    // Extension is computed before S1 so the stage registers only hold finished words.
    always_comb begin
        sx  = {{HI_W{imm[IMM_W-1]}}, imm};
        zx  = {{HI_W{1'b0}}, imm};
        res = '0;
        case (eop)
            3'b000:  res.ext = sx;
            3'b001:  res.ext = zx;
            3'b010:  res.ext = zx << HI_W;
            3'b011:  res.ext = sx << SHAMT;
            3'b100:  res.ext = zx << SHAMT;
            3'b101:  res.ext = {{HI_W{1'b1}}, imm};
            default: res.err = 1'b1;
        endcase
    end

    assign s1_adv   = s1_vld && (!s2_vld || out_ready);
    assign in_ready = !reset && (!s1_vld || s1_adv);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            s2_vld <= 1'b0;
            s2_dat <= '0;
        end else begin
            s1_vld <= accept || (s1_vld && !s1_adv);
            if (accept) begin
                s1_dat <= res;
            end
            // S2 data is left untouched on unload so ext/err keep their last value when empty.
            if (s1_adv) begin
                s2_vld <= 1'b1;
                s2_dat <= s1_dat;
            end else if (out_ready) begin
                s2_vld <= 1'b0;
            end
        end
    end

    assign out_valid = s2_vld;
    assign ext       = s2_dat.ext;
    assign err       = s2_dat.err;

`ifdef EXT_PIPE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (s2_vld && out_ready) begin
            cnt <= cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: default-parameter instance plus an 8->16 (SHAMT=3) instance on shared stimulus, scoreboard plus arithmetic model.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] imm;
    logic [2:0]  eop;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, err_a;
    logic [31:0] ext_a;
    logic        in_ready_b, out_valid_b, err_b;
    logic [15:0] ext_b;
`ifdef EXT_PIPE_CNT_EN
    logic [15:0] cnt_a, cnt_b;
`endif

    ext_pipe #(.IMM_W(16), .OUT_W(32), .SHAMT(2)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .imm(imm), .eop(eop), .out_valid(out_valid_a), .out_ready(out_ready),
        .ext(ext_a),
`ifdef EXT_PIPE_CNT_EN
        .cnt(cnt_a),
`endif
        .err(err_a)
    );

    ext_pipe #(.IMM_W(8), .OUT_W(16), .SHAMT(3)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .imm(imm[7:0]), .eop(eop), .out_valid(out_valid_b), .out_ready(out_ready),
        .ext(ext_b),
`ifdef EXT_PIPE_CNT_EN
        .cnt(cnt_b),
`endif
        .err(err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] imm;
        logic [2:0]  op;
        int          acc;
        bit          la;
        logic [31:0] lita;
        bit          lb;
        logic [15:0] litb;
    } item_t;

    item_t       q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          rst_q = 1'b0;
    logic [15:0] cnt_m = '0;

    bit          lit_a_vld = 0, lit_b_vld = 0;
    logic [31:0] lit_a = '0;
    logic [15:0] lit_b = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Extension rules as plain integer arithmetic modulo 2^ow.
    function automatic longint ref_ext(int iw, int ow, int sh, longint x, int op);
        longint one = 1;
        longint v = x & ((one << iw) - 1);
        longint s = (v >= (one << (iw - 1))) ? v - (one << iw) : v;
        longint r;
        case (op)
            0:       r = s;
            1:       r = v;
            2:       r = v * (one << (ow - iw));
            3:       r = s * (one << sh);
            4:       r = v * (one << sh);
            5:       r = (one << ow) - (one << iw) + v;
            default: r = 0;
        endcase
        return r & ((one << ow) - 1);
    endfunction

    always @(posedge clk) begin
        cyc++;
        rst_q <= reset;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_q) begin
                check("rst_out_valid_a", out_valid_a, 0);
                check("rst_ext_a", ext_a, 0);
                check("rst_err_a", err_a, 0);
                check("rst_out_valid_b", out_valid_b, 0);
                check("rst_ext_b", ext_b, 0);
            end
            if (reset) begin
                check("rst_in_ready_a", in_ready_a, 0);
                check("rst_in_ready_b", in_ready_b, 0);
                q.delete();
                cnt_m = '0;
            end else begin
                bit exp_ov, exp_ir;
                exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 1);
                exp_ir = !(q.size() == 2 && !out_ready);
                check("in_ready_a", in_ready_a, exp_ir);
                check("in_ready_b", in_ready_b, exp_ir);
                check("out_valid_a", out_valid_a, exp_ov);
                check("out_valid_b", out_valid_b, exp_ov);
                if (exp_ov) begin
                    item_t it;
                    it = q[0];
                    check("ext_a", ext_a, it.la ? it.lita : ref_ext(16, 32, 2, it.imm, it.op));
                    check("ext_b", ext_b, it.lb ? it.litb : ref_ext(8, 16, 3, it.imm, it.op));
                    check("err_a", err_a, it.op >= 6);
                    check("err_b", err_b, it.op >= 6);
                    if (out_ready) begin
                        void'(q.pop_front());
                        cnt_m = cnt_m + 16'd1;
                    end
                end
                if (in_valid && in_ready_a) begin
                    item_t it;
                    it.imm = imm; it.op = eop; it.acc = cyc + 1;
                    it.la = lit_a_vld; it.lita = lit_a; it.lb = lit_b_vld; it.litb = lit_b;
                    q.push_back(it);
                end
`ifdef EXT_PIPE_CNT_EN
                check("cnt_a", cnt_a, cnt_m);
                check("cnt_b", cnt_b, cnt_m);
`endif
            end
        end
    end

    task automatic step(output bit took);
        @(negedge clk);
        took = in_valid && in_ready_a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        bit t;
        in_valid = 0;
        for (int i = 0; i < n; i++) step(t);
    endtask

    task automatic send(input logic [15:0] i, input logic [2:0] o, input bit ha, input logic [31:0] la,
                        input bit hb, input logic [15:0] lb);
        bit took = 0;
        in_valid = 1; imm = i; eop = o;
        lit_a_vld = ha; lit_a = la; lit_b_vld = hb; lit_b = lb;
        for (int k = 0; k < 12 && !took; k++) step(took);
        check("send_accepted", took, 1);
        in_valid = 0; lit_a_vld = 0; lit_b_vld = 0;
    endtask

    initial begin
        bit took;
        int wi;
        reset = 1; in_valid = 0; imm = '0; eop = '0; out_ready = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        idle(2);

        // Directed extension values, streamed back to back.
        out_ready = 1;
        send(16'h8001, 3'b000, 1, 32'hFFFF8001, 0, '0);
        send(16'h7FFF, 3'b000, 1, 32'h00007FFF, 0, '0);
        send(16'hC003, 3'b001, 1, 32'h0000C003, 0, '0);
        send(16'hC003, 3'b010, 1, 32'hC0030000, 0, '0);
        send(16'hC003, 3'b011, 1, 32'hFFFF000C, 0, '0);
        send(16'hC003, 3'b100, 1, 32'h0003000C, 0, '0);
        send(16'hC003, 3'b101, 1, 32'hFFFFC003, 0, '0);
        send(16'h1234, 3'b110, 1, 32'h00000000, 0, '0);
        send(16'h1234, 3'b001, 1, 32'h00001234, 0, '0);
        send(16'h00F1, 3'b011, 1, 32'h000003C4, 1, 16'hFF88);
        idle(4);

        // Back-pressure: four words offered while the consumer stalls for five cycles.
        out_ready = 0; wi = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1; imm = 16'hA000 + 16'(wi); eop = 3'(wi);
            step(took);
            if (took) wi++;
        end
        check("bp_accepts", wi, 2);
        out_ready = 1;
        for (int c = 0; c < 10 && wi < 4; c++) begin
            in_valid = 1; imm = 16'hA000 + 16'(wi); eop = 3'(wi);
            step(took);
            if (took) wi++;
        end
        check("bp_all_accepted", wi, 4);
        idle(5);

        // Reset with both stages occupied.
        out_ready = 0;
        send(16'h1111, 3'b000, 0, '0, 0, '0);
        send(16'h2222, 3'b001, 0, '0, 0, '0);
        idle(1);
        reset = 1;
        idle(1);
        reset = 0;
        out_ready = 1;
        send(16'h8765, 3'b100, 1, 32'h0002_1D94, 0, '0);
        idle(4);

        // Randomized traffic with occasional resets; producer holds a word until it is taken.
        took = 1;
        for (int i = 0; i < 3000; i++) begin
            if (took || !in_valid) begin
                in_valid = ($urandom % 10) < 7;
                imm = 16'($urandom);
                eop = 3'($urandom);
            end
            out_ready = ($urandom % 10) < 6;
            reset = ($urandom % 300) == 0;
            step(took);
        end
        reset = 0;
        idle(2);

`ifdef EXT_PIPE_CNT_EN
        // Counter wrap: 16'hFFFE handshakes then three more.
        reset = 1;
        idle(1);
        reset = 0;
        out_ready = 1;
        for (int k = 0; k < 70000; k++) begin
            if (k > 100 && cnt_m == 16'h0001) break;
            in_valid = 1; imm = 16'($urandom); eop = 3'($urandom);
            step(took);
        end
        in_valid = 0; out_ready = 0;
        @(negedge clk);
        check("cnt_wrap_a", cnt_a, 16'h0001);
        @(posedge clk); #1;
`endif

        // Drain whatever is still in flight.
        in_valid = 0; out_ready = 1;
        for (int k = 0; k < 20 && q.size() > 0; k++) step(took);
        check("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
Parametrised, pipelined immediate extender: next generation of the single-cycle EOp extender used in the datapath. Accepts an IMM_W-bit immediate plus a 3-bit mode through a valid/ready handshake and delivers the OUT_W-bit extended word two cycles later through a valid/ready handshake. Used between the decode stage and the operand mux. Tolerates downstream back-pressure without losing or duplicating words.

Parameters:
IMM_W, 16, immediate width in bits (>= 2)
OUT_W, 32, result width in bits (must be > IMM_W)
SHAMT, 2, left-shift amount for the shifted modes (0 <= SHAMT < OUT_W)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer presents imm/eop this cycle
in_ready  output  1  block accepts imm/eop this cycle
imm  input  IMM_W  immediate to extend
eop  input  3  extension mode
out_valid  output  1  ext/err hold a valid result
out_ready  input  1  consumer takes the result this cycle
ext  output  OUT_W  extended result
err  output  1  result came from a reserved eop

Behaviour:
- Two register stages, S1 (compute) and S2 (output). Each holds a valid bit plus data.
- Accept: in_valid && in_ready. Computed result is written into S1 on the accepting edge.
- Advance S1->S2 when S1 is valid and (S2 is empty or out_ready).
- in_ready = !reset && (S1 empty || S1 advances this cycle). It is combinational from out_ready and the valid bits only, never from in_valid.
- Latency: a word accepted at edge N shows out_valid=1 after edge N+1. With out_ready held 1, throughput is one word per cycle.
- Output handshake: out_valid && out_ready. ext/err are driven straight from S2. While out_valid=1 && out_ready=0, ext/err stay stable.
- Modes (x = imm, sext/zext to OUT_W):
  000: sign-extend.
  001: zero-extend.
  010: high placement, x << (OUT_W-IMM_W), low bits 0.
  011: sext(x) << SHAMT.
  100: zext(x) << SHAMT.
  101: ones-fill, upper OUT_W-IMM_W bits = 1, low IMM_W bits = x.
  110, 111: reserved; ext = 0, err = 1.
- err = 0 for all legal modes.
- Width rule: shifted results are truncated to OUT_W bits. Bits shifted out are discarded silently.
- Full: S1 and S2 both valid and out_ready=0 gives in_ready=0. in_valid is ignored in that state.
- Simultaneous accept and output handshake while full: S2 unloads, S1 moves to S2, and the new word enters S1 in the same edge. No bubble is inserted.
- Empty: out_valid=0. ext/err keep their last value, and the consumer must ignore them.
- Reset, including mid-operation: both valid bits clear and in-flight words are dropped. ext=0, err=0, out_valid=0, in_ready=0 while reset=1. in_ready=1 on the first cycle after reset deasserts.

Optional Feature:
Macro EXT_PIPE_CNT_EN.
- Defined: adds output port cnt (16 bits), a count of completed output handshakes. Resets to 0, wraps from 16'hFFFF to 0, updates on the same edge as the handshake. Reserved-mode words are counted.
- Undefined: no port cnt and no counter logic. All other behaviour is identical.

Test Plan:
- Default params, eop=000, imm=16'h8001, out_ready=1 -> after 2 edges ext=32'hFFFF8001, err=0. Then imm=16'h7FFF -> 32'h00007FFF.
- eop=001/010/011/100/101 with imm=16'hC003 -> ext=32'h0000C003 / 32'hC0030000 / 32'hFFFF000C / 32'h0003000C / 32'hFFFFC003.
- eop=110, imm=16'h1234 -> ext=0, err=1. Next word eop=001 -> err=0.
- Back-pressure: stream 4 words, hold out_ready=0 for 5 cycles -> in_ready drops after 2 accepts and ext holds word 1. Release -> words 1..4 emerge in order, one per cycle, none lost or duplicated.
- Reset asserted with both stages full -> next cycle out_valid=0, ext=0, in_ready=0. After release, in_ready=1; a new word emerges 2 edges after acceptance.
- EXT_PIPE_CNT_EN, IMM_W=8, OUT_W=16, SHAMT=3 -> eop=011, imm=8'hF1 gives 16'hFF88. Preload 16'hFFFE handshakes, then 3 more -> cnt=16'h0001.
